// File: rtl/qam_demod.sv
// Coherent QPSK demodulator: mix with sin/cos references, integrate over one symbol,
// slice to 2 bits and re-serialise. Optional soft outputs: define QAM_DEMOD_SOFT_OUT_EN.
module qam_demod #(
    parameter int SAMPLE_W        = 16,
    parameter int SAMPLES_PER_SYM = 32,
    parameter int ACC_W           = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic signed [SAMPLE_W-1:0] sine_ref,
    input  logic signed [SAMPLE_W-1:0] cosine_ref,
    input  logic                       sym_start,
    output logic [1:0]                 sym_out,
    output logic                       sym_valid,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic                       sync_err
`ifdef QAM_DEMOD_SOFT_OUT_EN
    ,
    output logic signed [ACC_W-1:0]    soft_i,
    output logic signed [ACC_W-1:0]    soft_q
`endif
);
    localparam int PROD_W = 2 * SAMPLE_W;
    localparam int CNT_W  = $clog2(SAMPLES_PER_SYM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);

    typedef enum logic [1:0] {ACQ, INTEG, DUMP} state_t;

    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [SAMPLE_W-1:0] a,
        input logic signed [SAMPLE_W-1:0] b
    );
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        ax = {{SAMPLE_W{a[SAMPLE_W-1]}}, a};
        bx = {{SAMPLE_W{b[SAMPLE_W-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic slice(input logic signed [ACC_W-1:0] a);
        return ~a[ACC_W-1];
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take, first, last, err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACQ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // DUMP behaves like count 0 so a sample arriving right after the last one starts the next symbol
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            ACQ: begin
                if (en && sym_start) begin
                    take    = 1'b1;
                    first   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = INTEG;
                end
            end
            INTEG, DUMP: begin
                state_d = INTEG;
                if (en) begin
                    take = 1'b1;
                    if (cnt_q == '0 || sym_start) begin
                        first = 1'b1;
                        err   = sym_start && (cnt_q != '0);
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q == LAST_CNT) begin
                        last    = 1'b1;
                        cnt_d   = '0;
                        state_d = DUMP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ACQ;
        endcase
    end

    logic signed [PROD_W-1:0] prod_i_p1_q, prod_q_p1_q;
    logic                     vld_p1_q, first_p1_q, last_p1_q, err_p1_q;
    logic signed [ACC_W-1:0]  acc_i_p2_q, acc_q_p2_q;
    logic                     dump_p2_q;
    logic [1:0]               sym_q;
    logic                     sym_vld_q, bit_q, bit_vld_q, bit2_pend_q, sync_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_i_p1_q <= '0;
            prod_q_p1_q <= '0;
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            err_p1_q    <= 1'b0;
            acc_i_p2_q  <= '0;
            acc_q_p2_q  <= '0;
            dump_p2_q   <= 1'b0;
            sym_q       <= 2'b00;
            sym_vld_q   <= 1'b0;
            bit_q       <= 1'b0;
            bit_vld_q   <= 1'b0;
            bit2_pend_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            // Stage 1: mix
            vld_p1_q   <= take;
            first_p1_q <= first;
            last_p1_q  <= last;
            err_p1_q   <= err;
            if (take) begin
                prod_i_p1_q <= mul_full(sample_in, sine_ref);
                prod_q_p1_q <= mul_full(sample_in, cosine_ref);
            end
            // Stage 2: integrate
            dump_p2_q  <= vld_p1_q && last_p1_q;
            sync_err_q <= err_p1_q;
            if (vld_p1_q) begin
                if (first_p1_q) begin
                    acc_i_p2_q <= sext(prod_i_p1_q);
                    acc_q_p2_q <= sext(prod_q_p1_q);
                end else begin
                    acc_i_p2_q <= acc_i_p2_q + sext(prod_i_p1_q);
                    acc_q_p2_q <= acc_q_p2_q + sext(prod_q_p1_q);
                end
            end
            // Stage 3: slice
            sym_vld_q <= dump_p2_q;
            if (dump_p2_q) begin
                sym_q <= {slice(acc_i_p2_q), slice(acc_q_p2_q)};
            end
            // Serialiser: sine bit first, then cosine bit
            if (sym_vld_q) begin
                bit_q       <= sym_q[1];
                bit_vld_q   <= 1'b1;
                bit2_pend_q <= 1'b1;
            end else if (bit2_pend_q) begin
                bit_q       <= sym_q[0];
                bit_vld_q   <= 1'b1;
                bit2_pend_q <= 1'b0;
            end else begin
                bit_vld_q   <= 1'b0;
            end
        end
    end

`ifdef QAM_DEMOD_SOFT_OUT_EN
    logic signed [ACC_W-1:0] soft_i_q, soft_q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            soft_i_q <= '0;
            soft_q_q <= '0;
        end else if (dump_p2_q) begin
            soft_i_q <= acc_i_p2_q;
            soft_q_q <= acc_q_p2_q;
        end
    end

    assign soft_i = soft_i_q;
    assign soft_q = soft_q_q;
`endif

    assign sym_out   = sym_q;
    assign sym_valid = sym_vld_q;
    assign bit_out   = bit_q;
    assign bit_valid = bit_vld_q;
    assign sync_err  = sync_err_q;

endmodule
